// File: rtl/inert_read_sequencer.sv
// IMU read sequencer: waits out sensor power-up, programs four init registers over
// the shared SPI monarch, then reads pitch rate and Z acceleration per data-ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT_WAIT | sensor power-up wait, timer counts up to all-ones
// INIT1..4  | one init register write each (int cfg, accel, gyro, rounding)
// IDLE      | waiting for synchronized data-ready
// RD_PL..AH | one byte read each: pitch low/high, AZ low/high
// VALID     | ptch_rt/AZ freshly loaded, vld high for this clk
module inert_read_sequencer #(
    parameter int INIT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        VALID
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [INIT_BITS-1:0] timer;
    logic                 timer_tc;
    logic                 int_meta;
    logic                 int_s;
    logic                 cmd_state;
    logic                 cmd_done;
    logic [7:0]           pl;
    logic [7:0]           ph;
    logic [7:0]           al;
    logic [7:0]           unused_rd_hi;

    assign unused_rd_hi = rd_data[15:8];

    function automatic logic is_cmd(input state_t s);
        logic r;
        case (s)
            INIT1, INIT2, INIT3, INIT4,
            RD_PL, RD_PH, RD_AL, RD_AH: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    assign timer_tc  = &timer;
    assign cmd_state = is_cmd(state);
    // A done landing in the same clk as wrt belongs to no transaction we started.
    assign cmd_done  = done & ~wrt & cmd_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_WAIT;
            wrt   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= next_state;
            wrt   <= is_cmd(next_state) && (next_state != state);
            vld   <= (state == RD_AH) && cmd_done;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            INIT_WAIT: if (timer_tc) next_state = INIT1;
            INIT1:     if (cmd_done) next_state = INIT2;
            INIT2:     if (cmd_done) next_state = INIT3;
            INIT3:     if (cmd_done) next_state = INIT4;
            INIT4:     if (cmd_done) next_state = IDLE;
            IDLE:      if (int_s)    next_state = RD_PL;
            RD_PL:     if (cmd_done) next_state = RD_PH;
            RD_PH:     if (cmd_done) next_state = RD_AL;
            RD_AL:     if (cmd_done) next_state = RD_AH;
            RD_AH:     if (cmd_done) next_state = VALID;
            VALID:                   next_state = IDLE;
            default:                 next_state = INIT_WAIT;
        endcase
    end

    always_comb begin
        cmd = 16'h0000;
        unique case (state)
            INIT1:   cmd = 16'h0D02;
            INIT2:   cmd = 16'h1053;
            INIT3:   cmd = 16'h1150;
            INIT4:   cmd = 16'h1460;
            RD_PL:   cmd = 16'hA200;
            RD_PH:   cmd = 16'hA300;
            RD_AL:   cmd = 16'hAC00;
            RD_AH:   cmd = 16'hAD00;
            default: cmd = 16'h0000;
        endcase
    end

    // Timer saturates at all-ones; only reset restarts the power-up wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((state == INIT_WAIT) && !timer_tc) begin
            timer <= timer + {{(INIT_BITS-1){1'b0}}, 1'b1};
        end
    end

    // The AH byte goes straight into AZ on the final done edge, so it needs no hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl      <= 8'h00;
            ph      <= 8'h00;
            al      <= 8'h00;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
        end else if (cmd_done) begin
            case (state)
                RD_PL: pl <= rd_data[7:0];
                RD_PH: ph <= rd_data[7:0];
                RD_AL: al <= rd_data[7:0];
                RD_AH: begin
                    ptch_rt <= {ph, pl};
                    AZ      <= {rd_data[7:0], al};
                end
                default: ;
            endcase
        end
    end

endmodule
